// File: rtl/mmio_uart_tx.sv
// +--------------------------------------------------------------------------+
// | Module   : mmio_uart_tx                                                  |
// | Function : MMIO-mapped 8N1 UART transmitter with a byte FIFO, a         |
// |            programmable baud divisor and a 4-register CSR window.        |
// | Options  : define MMIO_UART_TX_IRQ_EN to add the o_irq port and the     |
// |            CTRL.irq_en bit (STATUS bit4 then mirrors o_irq).             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module mmio_uart_tx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [29:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_wren,
  input  logic [3:0]  i_mask,
  output logic [31:0] o_data,
  output logic        o_tx
`ifdef MMIO_UART_TX_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  localparam int              c_aw        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              c_cw        = c_aw + 1;
  localparam logic [c_aw-1:0] c_ptr_one   = 1;
  localparam logic [c_cw-1:0] c_cnt_one   = 1;
  localparam logic [c_cw-1:0] c_full_cnt  = c_cw'(FIFO_DEPTH);
  localparam logic [15:0]     c_reset_div = 16'(DEFAULT_DIV);

  // Serializer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Register file and FIFO storage
  // ---------------------------------------------------------------------------
  logic [7:0]      fifo_mem_q [FIFO_DEPTH];
  logic [c_aw-1:0] wr_ptr_q;
  logic [c_aw-1:0] rd_ptr_q;
  logic [c_cw-1:0] count_q;
  logic            ovf_q;
  logic [15:0]     div_q;
  logic            en_q;

  // Serializer state
  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [15:0]     div_lat_q, div_lat_d;
  logic            tx_q, tx_d;

  // Combinational helpers
  logic            w_wr_txdata;
  logic            w_wr_status;
  logic            w_wr_div;
  logic            w_wr_ctrl;
  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_busy;
  logic            w_can_start;
  logic            w_bit_done;
  logic [15:0]     w_div_eff;
  logic [7:0]      w_head;
  logic [7:0]      w_count8;
  logic            w_irq_bit;
  logic [31:0]     w_ctrl_rd;
  logic            w_unused_bits;

  // Write decode: a write only lands when the full word offset matches
  assign w_wr_txdata = i_wren && (i_addr == 30'd0);
  assign w_wr_status = i_wren && (i_addr == 30'd1);
  assign w_wr_div    = i_wren && (i_addr == 30'd2);
  assign w_wr_ctrl   = i_wren && (i_addr == 30'd3);

  // A full FIFO still takes a byte when the serializer pops in the same cycle
  assign w_full      = (count_q == c_full_cnt);
  assign w_empty     = (count_q == '0);
  assign w_push_req  = w_wr_txdata && i_mask[0];
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_head      = fifo_mem_q[rd_ptr_q];

  assign w_busy      = (state_q != S_IDLE);
  assign w_can_start = !w_empty && en_q;
  assign w_div_eff   = (div_lat_q == 16'd0) ? 16'd1 : div_lat_q;
  assign w_bit_done  = (cnt_q == (w_div_eff - 16'd1));

  assign w_count8    = 8'(count_q);
  assign o_tx        = tx_q;

  // Upper data lanes and mask bits have no register behind them
  assign w_unused_bits = ^{i_data[31:16], i_mask[3:2]};

  // FIFO storage; flushing is done through the pointers, so no reset here
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      fifo_mem_q[wr_ptr_q] <= i_data[7:0];
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + c_ptr_one;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + c_cnt_one;
        2'b01:   count_q <= count_q - c_cnt_one;
        default: count_q <= count_q;
      endcase
      if (w_push_req && !w_push) begin
        ovf_q <= 1'b1;
      end else if (w_wr_status && i_mask[0] && i_data[3]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Software-visible DIV and CTRL registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q <= c_reset_div;
      en_q  <= 1'b1;
    end else begin
      if (w_wr_div && i_mask[0]) begin
        div_q[7:0] <= i_data[7:0];
      end
      if (w_wr_div && i_mask[1]) begin
        div_q[15:8] <= i_data[15:8];
      end
      if (w_wr_ctrl && i_mask[0]) begin
        en_q <= i_data[0];
      end
    end
  end

  // Serializer state register; o_tx is registered so it lags the state by one cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      div_lat_q <= c_reset_div;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      div_lat_q <= div_lat_d;
      tx_q      <= tx_d;
    end
  end

  // Serializer next-state, FIFO pop and line level
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    div_lat_d = div_lat_q;
    w_pop     = 1'b0;
    tx_d      = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (w_can_start) begin
          w_pop     = 1'b1;
          shift_d   = w_head;
          div_lat_d = div_q;
          cnt_d     = 16'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          cnt_d   = 16'd0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          cnt_d   = 16'd0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          cnt_d = 16'd0;
          // Chain straight into the next start bit so frames carry no gap
          if (w_can_start) begin
            w_pop     = 1'b1;
            shift_d   = w_head;
            div_lat_d = div_q;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

`ifdef MMIO_UART_TX_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  // Interrupt enable bit and the registered "transmitter drained" interrupt
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (w_wr_ctrl && i_mask[0]) begin
        irq_en_q <= i_data[1];
      end
      irq_q <= irq_en_q && w_empty && !w_busy;
    end
  end

  assign o_irq     = irq_q;
  assign w_irq_bit = irq_q;
  assign w_ctrl_rd = {30'd0, irq_en_q, en_q};
`else
  assign w_irq_bit = 1'b0;
  assign w_ctrl_rd = {31'd0, en_q};
`endif

  // Combinational read mux; reads never alter state
  always_comb begin
    o_data = 32'd0;
    case (i_addr)
      30'd1:   o_data = {16'd0, w_count8, 3'd0, w_irq_bit, ovf_q, w_busy, w_empty, w_full};
      30'd2:   o_data = {16'd0, div_q};
      30'd3:   o_data = w_ctrl_rd;
      default: o_data = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_mmio_uart_tx                                               |
// | Function : Directed self-checking bench for mmio_uart_tx.                |
// | Options  : define MMIO_UART_TX_IRQ_EN to also exercise o_irq.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mmio_uart_tx;

  logic        i_clk;
  logic        i_rst;
  logic [29:0] i_addr;
  logic [31:0] i_data;
  logic        i_wren;
  logic [3:0]  i_mask;
  logic [31:0] o_data;
  logic        o_tx;
`ifdef MMIO_UART_TX_IRQ_EN
  logic        o_irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mmio_uart_tx #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (434)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_addr (i_addr),
    .i_data (i_data),
    .i_wren (i_wren),
    .i_mask (i_mask),
    .o_data (o_data),
    .o_tx   (o_tx)
`ifdef MMIO_UART_TX_IRQ_EN
    ,
    .o_irq  (o_irq)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Single-cycle register write; returns 1 time unit after the committing edge
  task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge i_clk);
    i_addr = a;
    i_data = d;
    i_mask = m;
    i_wren = 1'b1;
    @(posedge i_clk);
    #1;
    i_wren = 1'b0;
    i_mask = 4'h0;
  endtask

  // Combinational register read
  task automatic rd(input logic [29:0] a, output logic [31:0] d);
    i_addr = a;
    #1;
    d = o_data;
  endtask

  // Cycle-by-cycle frame check. Cycle k is sampled 1 unit after edge E_k,
  // where E_0 is the edge that committed the first TXDATA write.
  task automatic check_frames(input logic [7:0] b0, input logic [7:0] b1,
                              input int nframes, input int div, input int k0,
                              input string tag);
    int         flen;
    int         total;
    int         j;
    int         pos;
    logic [7:0] b;
    logic       exp_tx;
    logic       exp_busy;
    logic       exp_empty;
    flen  = 10 * div;
    total = nframes * flen;
    i_addr = 30'd1;
    for (int k = k0; k <= total + 2; k++) begin
      @(posedge i_clk);
      #1;
      j = k - 2;
      exp_tx = 1'b1;
      if (j >= 0 && j < total) begin
        b   = ((j / flen) == 0) ? b0 : b1;
        pos = (j % flen) / div;
        if (pos == 0)      exp_tx = 1'b0;
        else if (pos == 9) exp_tx = 1'b1;
        else               exp_tx = b[pos-1];
      end
      exp_busy  = (k >= 1) && (k <= total);
      exp_empty = (k >= 1 + flen * (nframes - 1));
      n_checks++;
      if (o_tx !== exp_tx) begin
        n_fail++;
        $display("FAIL %s_tx k=%0d o_tx=%b expected %b", tag, k, o_tx, exp_tx);
      end
      n_checks++;
      if (o_data[2] !== exp_busy) begin
        n_fail++;
        $display("FAIL %s_busy k=%0d busy=%b expected %b", tag, k, o_data[2], exp_busy);
      end
      n_checks++;
      if (o_data[1] !== exp_empty) begin
        n_fail++;
        $display("FAIL %s_empty k=%0d empty=%b expected %b", tag, k, o_data[1], exp_empty);
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    n_checks++;
    if (o_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tx o_tx=%b expected 1", o_tx);
    end
    rd(30'd0, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_txdata read=%h expected 00000000", d);
    end
    rd(30'd1, d);
    n_checks++;
    if (d !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL reset_status read=%h expected 00000002", d);
    end
    rd(30'd2, d);
    n_checks++;
    if (d !== 32'd434) begin
      n_fail++;
      $display("FAIL reset_div read=%h expected 000001b2", d);
    end
    rd(30'd3, d);
    n_checks++;
    if (d !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL reset_ctrl read=%h expected 00000001", d);
    end
  endtask

  task automatic test_single_frame;
    wr(30'd2, 32'd4, 4'b0011);
    wr(30'd0, 32'h0000_0055, 4'b0001);
    check_frames(8'h55, 8'h55, 1, 4, 1, "frame55");
  endtask

  task automatic test_back_to_back;
    wr(30'd2, 32'd2, 4'b0011);
    wr(30'd0, 32'h0000_00A1, 4'b0001);
    wr(30'd0, 32'h0000_003C, 4'b0001);
    check_frames(8'hA1, 8'h3C, 2, 2, 2, "b2b");
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    wr(30'd3, 32'd0, 4'b0001);
    for (int i = 0; i < 9; i++) begin
      wr(30'd0, 32'h10 + 32'(i), 4'b0001);
    end
    rd(30'd1, d);
    n_checks++;
    if (d !== 32'h0000_0809) begin
      n_fail++;
      $display("FAIL ovf_status read=%h expected 00000809", d);
    end
    wr(30'd1, 32'h0000_0008, 4'b0001);
    rd(30'd1, d);
    n_checks++;
    if (d !== 32'h0000_0801) begin
      n_fail++;
      $display("FAIL ovf_w1c read=%h expected 00000801", d);
    end
    // Drain the eight queued bytes quickly with DIV=0 (one cycle per bit)
    wr(30'd2, 32'd0, 4'b0011);
    wr(30'd3, 32'd1, 4'b0001);
    repeat (100) @(posedge i_clk);
    rd(30'd1, d);
    n_checks++;
    if (d !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL ovf_drain read=%h expected 00000002", d);
    end
  endtask

  task automatic test_mask_and_offsets;
    logic [31:0] d;
    wr(30'd3, 32'd0, 4'b0001);
    wr(30'd0, 32'h0000_00FF, 4'b1110);
    rd(30'd1, d);
    n_checks++;
    if (d !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL mask_nopush status=%h expected 00000002", d);
    end
    rd(30'd5, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL off5_read read=%h expected 00000000", d);
    end
    wr(30'd5, 32'hFFFF_FFFF, 4'b1111);
    rd(30'd2, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL off5_write div=%h expected 00000000", d);
    end
    rd(30'd3, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL off5_write ctrl=%h expected 00000000", d);
    end
    wr(30'd3, 32'd1, 4'b0001);
    wr(30'd0, 32'h0000_00FF, 4'b0001);
    check_frames(8'hFF, 8'hFF, 1, 1, 1, "div0");
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    wr(30'd2, 32'd4, 4'b0011);
    wr(30'd0, 32'h0000_0055, 4'b0001);
    wr(30'd0, 32'h0000_000F, 4'b0001);
    // Now at E1+1; data bit 3 of 0x55 (a zero) is on the line for k=18..21
    repeat (18) @(posedge i_clk);
    #1;
    n_checks++;
    if (o_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_bit3 o_tx=%b expected 0", o_tx);
    end
    #2;
    i_rst = 1'b1;
    #1;
    n_checks++;
    if (o_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_async o_tx=%b expected 1", o_tx);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    rd(30'd1, d);
    n_checks++;
    if (d !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL midrst_status read=%h expected 00000002", d);
    end
    rd(30'd2, d);
    n_checks++;
    if (d !== 32'd434) begin
      n_fail++;
      $display("FAIL midrst_div read=%h expected 000001b2", d);
    end
    rd(30'd3, d);
    n_checks++;
    if (d !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL midrst_ctrl read=%h expected 00000001", d);
    end
    i_addr = 30'd1;
    for (int k = 0; k < 20; k++) begin
      @(posedge i_clk);
      #1;
      n_checks++;
      if (o_tx !== 1'b1 || o_data[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_idle k=%0d o_tx=%b busy=%b expected 1 0", k, o_tx, o_data[2]);
      end
    end
  endtask

`ifdef MMIO_UART_TX_IRQ_EN
  task automatic test_irq;
    logic exp_irq;
    wr(30'd2, 32'd1, 4'b0011);
    wr(30'd3, 32'd3, 4'b0001);
    i_addr = 30'd1;
    @(posedge i_clk);
    #1;
    n_checks++;
    if (o_irq !== 1'b1 || o_data[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_idle o_irq=%b status4=%b expected 1 1", o_irq, o_data[4]);
    end
    wr(30'd0, 32'h0000_005A, 4'b0001);
    i_addr = 30'd1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge i_clk);
      #1;
      exp_irq = (k >= 12);
      n_checks++;
      if (o_irq !== exp_irq || o_data[4] !== exp_irq) begin
        n_fail++;
        $display("FAIL irq_frame k=%0d o_irq=%b status4=%b expected %b", k, o_irq, o_data[4], exp_irq);
      end
    end
    wr(30'd3, 32'd1, 4'b0001);
    @(posedge i_clk);
    #1;
    n_checks++;
    if (o_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear o_irq=%b expected 0", o_irq);
    end
  endtask
`endif

  initial begin
    i_rst  = 1'b1;
    i_addr = 30'd0;
    i_data = 32'd0;
    i_wren = 1'b0;
    i_mask = 4'h0;
    repeat (3) @(posedge i_clk);
    #1;
    test_reset;
    @(negedge i_clk);
    i_rst = 1'b0;
    test_single_frame;
    test_back_to_back;
    test_overflow;
    test_mask_and_offsets;
    test_reset_midframe;
`ifdef MMIO_UART_TX_IRQ_EN
    test_irq;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
